// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multicycle MIPS controller: state encodings,
// opcodes, mux select codes and the internal control bundle.
package multicycle_controller_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // pc_write is the unconditional PC load; branch qualifies a load by Zero.
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

  function automatic logic is_wait_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// Memory wait counter: counts 0..LAT-1 while enabled, flags the last wait
// cycle, and returns to zero whenever the controller leaves a state.
module mc_wait_counter #(
  parameter int unsigned LAT = 1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic en,
  input  logic clear,
  output logic last
);

  localparam logic [3:0] LAST_CNT = 4'(LAT - 1);

  logic [3:0] count;

  assign last = (count == LAST_CNT);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style multicycle MIPS controller with a parameterised memory latency;
// only PCEn looks at Zero combinationally.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       PCEn,
  output logic [3:0] State
);

  logic [3:0] state;
  logic [3:0] next_state;
  logic       wait_last;
  ctrl_t      ctrl;

  mc_wait_counter #(
    .LAT(MEM_LAT)
  ) u_wait (
    .Clk  (Clk),
    .Rst  (Rst),
    .en   (is_wait_state(state)),
    .clear(next_state != state),
    .last (wait_last)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every variable written in a combinational block gets a default
  // first, so no path through the case can infer a latch.
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = wait_last ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR: next_state = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  next_state = wait_last ? S_MEMWB : S_MEMRD;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  next_state = wait_last ? S_FETCH : S_MEMWR;
      S_EXEC:   next_state = S_ALUWB;
      S_ALUWB:  next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      S_ADDIEX: next_state = S_ADDIWB;
      S_ADDIWB: next_state = S_FETCH;
      S_JUMP:   next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = wait_last;
        ctrl.pc_write  = wait_last;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = wait_last;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  // While Rst is high the state already reads FETCH; only the strobes need masking.
  assign IorD     = ctrl.iord;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write & ~Rst;
  assign IRWrite  = ctrl.ir_write & ~Rst;
  assign RegDst   = ctrl.reg_dst;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegWrite = ctrl.reg_write & ~Rst;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign ALUOp    = ctrl.alu_op;
  assign PCSource = ctrl.pc_source;
  assign PCEn     = ~Rst & (ctrl.pc_write | (ctrl.branch & Zero));
  assign State    = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: three instances (MEM_LAT 1..3) driven in
// turn; each instruction is expanded into its expected per-cycle state trace.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] state;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_en;
  } obs_t;

  typedef struct packed {
    logic [3:0] st;
    logic       last;
  } phase_t;

  logic       Clk_tb = 1'b0;
  logic       rst  [3];
  logic [5:0] opc  [3];
  logic       zero [3];
  obs_t       obs  [3];

  int checks = 0;
  int errors = 0;

  always #5 Clk_tb = ~Clk_tb;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a, pc_en;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    multicycle_controller #(
      .MEM_LAT(g + 1)
    ) u_dut (
      .Clk     (Clk_tb),
      .Rst     (rst[g]),
      .Opcode  (opc[g]),
      .Zero    (zero[g]),
      .IorD    (iord),
      .MemRead (mem_read),
      .MemWrite(mem_write),
      .IRWrite (ir_write),
      .RegDst  (reg_dst),
      .MemtoReg(mem_to_reg),
      .RegWrite(reg_write),
      .ALUSrcA (alu_src_a),
      .ALUSrcB (alu_src_b),
      .ALUOp   (alu_op),
      .PCSource(pc_source),
      .PCEn    (pc_en),
      .State   (state)
    );

    assign obs[g] = {state, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                     reg_write, alu_src_a, alu_src_b, alu_op, pc_source, pc_en};
  end

  // Expected outputs of one cycle, straight from the per-state output table.
  function automatic obs_t expect_ctrl(logic [3:0] st, logic last, logic z, logic r);
    obs_t e = '0;
    e.state = st;
    case (st)
      4'd0: begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = last; e.pc_en = last; end
      4'd1: e.alu_src_b = 2'b11;
      4'd2: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      4'd3: begin e.iord = 1; e.mem_read = 1; end
      4'd4: begin e.mem_to_reg = 1; e.reg_write = 1; end
      4'd5: begin e.iord = 1; e.mem_write = last; end
      4'd6: begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      4'd7: begin e.reg_dst = 1; e.reg_write = 1; end
      4'd8: begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_source = 2'b01; e.pc_en = z; end
      4'd9: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      4'd10: e.reg_write = 1;
      4'd11: begin e.pc_source = 2'b10; e.pc_en = 1; end
      default: ;
    endcase
    if (r) begin
      e.ir_write = 0; e.pc_en = 0; e.mem_write = 0; e.reg_write = 0;
    end
    return e;
  endfunction

  task automatic check(string tag, obs_t got, obs_t exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic known_op(logic [5:0] o);
    return o inside {6'd0, 6'd2, 6'd4, 6'd8, 6'd35, 6'd43};
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] o;
    case ($urandom_range(0, 6))
      0: o = 6'b100011;
      1: o = 6'b101011;
      2: o = 6'b000000;
      3: o = 6'b000100;
      4: o = 6'b001000;
      5: o = 6'b000010;
      default: begin
        o = 6'($urandom);
        while (known_op(o)) o = 6'($urandom);
      end
    endcase
    return o;
  endfunction

  // Called at posedge+1; holds reset two cycles with checks, then releases.
  task automatic reset_and_release(int i);
    rst[i] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      opc[i]  = 6'($urandom);
      zero[i] = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("reset L%0d c%0d", i + 1, c), obs[i], expect_ctrl(4'd0, 1'b0, zero[i], 1'b1));
      @(posedge Clk_tb); #1;
    end
    rst[i] = 1'b0;
  endtask

  // zmode <0 randomises Zero each cycle; abort_at >=0 asserts Rst mid-cycle at that step.
  task automatic run_instr(int i, logic [5:0] op, int zmode, int abort_at, string name);
    phase_t q[$];
    int lat = i + 1;
    for (int k = 0; k < lat; k++) q.push_back('{st: 4'd0, last: (k == lat - 1)});
    q.push_back('{st: 4'd1, last: 1'b0});
    case (op)
      6'b100011: begin
        q.push_back('{st: 4'd2, last: 1'b0});
        for (int k = 0; k < lat; k++) q.push_back('{st: 4'd3, last: (k == lat - 1)});
        q.push_back('{st: 4'd4, last: 1'b0});
      end
      6'b101011: begin
        q.push_back('{st: 4'd2, last: 1'b0});
        for (int k = 0; k < lat; k++) q.push_back('{st: 4'd5, last: (k == lat - 1)});
      end
      6'b000000: begin q.push_back('{st: 4'd6, last: 1'b0}); q.push_back('{st: 4'd7, last: 1'b0}); end
      6'b000100: q.push_back('{st: 4'd8, last: 1'b0});
      6'b001000: begin q.push_back('{st: 4'd9, last: 1'b0}); q.push_back('{st: 4'd10, last: 1'b0}); end
      6'b000010: q.push_back('{st: 4'd11, last: 1'b0});
      default: ;
    endcase
    for (int k = 0; k < q.size(); k++) begin
      // Opcode is only meaningful once the IR is loaded; scramble it during FETCH.
      opc[i]  = (q[k].st == 4'd0) ? 6'($urandom) : op;
      zero[i] = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      check($sformatf("%s L%0d op%0h s%0d", name, lat, op, k), obs[i],
            expect_ctrl(q[k].st, q[k].last, zero[i], 1'b0));
      if (k == abort_at) begin
        rst[i] = 1'b1;
        #1;
        check($sformatf("%s L%0d async_rst", name, lat), obs[i], expect_ctrl(4'd0, 1'b0, zero[i], 1'b1));
        @(posedge Clk_tb); #1;
        check($sformatf("%s L%0d held_rst", name, lat), obs[i], expect_ctrl(4'd0, 1'b0, zero[i], 1'b1));
        rst[i] = 1'b0;
        return;
      end
      @(posedge Clk_tb); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i]  = 1'b1;
      opc[i]  = '0;
      zero[i] = 1'b0;
    end
    @(posedge Clk_tb); #1;

    for (int i = 0; i < 3; i++) begin
      reset_and_release(i);
      case (i)
        0: begin
          run_instr(0, 6'b100011, -1, -1, "lw");
          run_instr(0, 6'b000100, 1, -1, "beq_taken");
          run_instr(0, 6'b000100, 0, -1, "beq_not_taken");
          run_instr(0, 6'b111111, -1, -1, "nop");
          run_instr(0, 6'b000000, -1, -1, "rtype");
          run_instr(0, 6'b001000, -1, -1, "addi");
          run_instr(0, 6'b000010, -1, -1, "j");
        end
        1: begin
          run_instr(1, 6'b101011, -1, -1, "sw");
          run_instr(1, 6'b100011, -1, -1, "lw");
        end
        default: begin
          // Steps 5..7 are MEMRD; abort in the middle one.
          run_instr(2, 6'b100011, -1, 6, "lw_abort");
          run_instr(2, 6'b000000, -1, -1, "after_abort");
          run_instr(2, 6'b101011, -1, -1, "sw");
        end
      endcase
      for (int n = 0; n < 40; n++) run_instr(i, pick_op(), -1, -1, "rand");
      rst[i] = 1'b1;
      @(posedge Clk_tb); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: MEM_LAT, default 1, memory access latency in cycles (legal 1..15).
REQ-002 Clk  input  1  system clock; all state changes on rising edge.
REQ-003 Rst  input  1  reset; asynchronous, active-high.
REQ-004 Opcode  input  6  instruction [31:26] from instruction register.
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-007 MemRead  output  1  memory read enable.
REQ-008 MemWrite  output  1  memory write strobe.
REQ-009 IRWrite  output  1  instruction register load.
REQ-010 RegDst  output  1  destination register: 0 = rt, 1 = rd.
REQ-011 MemtoReg  output  1  writeback source: 0 = ALUOut, 1 = MDR.
REQ-012 RegWrite  output  1  register file write enable.
REQ-013 ALUSrcA  output  1  ALU A: 0 = PC, 1 = reg A.
REQ-014 ALUSrcB  output  2  ALU B: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm << 2.
REQ-015 ALUOp  output  2  00 add, 01 subtract, 10 decode by funct.
REQ-016 PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-017 PCEn  output  1  PC load = unconditional write OR (branch AND Zero).
REQ-018 State  output  4  current state encoding, for debug.

Function
REQ-019 Moore FSM; all outputs except PCEn decoded from State and wait counter only; PCEn additionally depends combinationally on Zero.
REQ-020 States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11; encodings 12-15 unused.
REQ-021 FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=1 and PCEn=1 only on last wait cycle; then -> DECODE.
REQ-022 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next by Opcode: 100011 or 101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP, any other -> FETCH (treated as NOP).
REQ-023 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; lw -> MEMRD, sw -> MEMWR.
REQ-024 MEMRD: IorD=1, MemRead=1 all wait cycles; -> MEMWB after last. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; -> FETCH.
REQ-025 MEMWR: IorD=1; MemWrite=1 only on last wait cycle (single-cycle strobe); -> FETCH.
REQ-026 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; -> ALUWB. ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; -> FETCH.
REQ-027 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCEn=Zero; -> FETCH.
REQ-028 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; -> ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; -> FETCH.
REQ-029 JUMP: PCSource=10, PCEn=1; -> FETCH.
REQ-030 Outputs not listed for a state are 0.
REQ-031 Wait counter (4 bit) counts 0..MEM_LAT-1 in FETCH, MEMRD, MEMWR; "last wait cycle" = count MEM_LAT-1; counter clears on every state exit; MEM_LAT=1 gives single-cycle memory states.
REQ-032 Unused encodings -> FETCH next cycle, all outputs 0.
REQ-033 Instruction latency with MEM_LAT=1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2 cycles.

Reset
REQ-034 Rst high: State=FETCH, counter=0 immediately, independent of Clk.
REQ-035 While Rst high: IRWrite, PCEn, MemWrite, RegWrite forced 0; other outputs per FETCH.
REQ-036 Rst asserted mid-instruction abandons it with no further write strobes; first edge after release performs FETCH cycle 0.

Structure
REQ-037 Shared package/header: state encodings, opcode constants, ALUOp and PCSource codes.
REQ-038 One sub-module natural: mc_wait_counter (count, last-cycle flag, clear).

Verification
REQ-039 Rst=1 mid-MEMRD, MEM_LAT=3 -> State=0 same cycle, no RegWrite; after release FETCH lasts 3 cycles, IRWrite only on third.
REQ-040 MEM_LAT=1, lw (Opcode 100011) -> States 0,1,2,3,4,0; RegWrite=1 MemtoReg=1 only in state 4.
REQ-041 beq with Zero=1 -> PCEn=1, PCSource=01 in BRANCH; Zero=0 -> PCEn=0; 3 cycles back to FETCH.
REQ-042 sw, MEM_LAT=2 -> MEMWR held 2 cycles, MemWrite high exactly one cycle (second).
REQ-043 Opcode 111111 -> States 0,1,0; no RegWrite/MemWrite ever.
REQ-044 Back-to-back R-type, addi, j -> 4+4+3 cycles; RegDst=1 in ALUWB, 0 in ADDIWB; PCSource=10 in JUMP.
